// File: rtl/uart_csr_bank.sv
// UART control/status register bank: CTRL/BAUD/IRQ_EN registers, W1C status,
// saturating error counters, a one-word TX holding register and the RX FIFO read port.
module uart_csr_bank #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = 8,
  parameter int BAUD_RST = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              slverr,
  output logic [DATA_W-1:0] config_reg,
  output logic [DATA_W-1:0] baud_div,
  output logic              irq,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_pop,
  input  logic              parity_error,
  input  logic              frame_error,
  input  logic              overrun,
  input  logic              threshold,
  input  logic [3:0]        err_id
);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TX     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_RX     = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_IRQEN  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_ERRCNT = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_BAUD   = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_FIRST_UNMAPPED = ADDR_W'(7);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [6:0]        irq_en_q;
  logic              par_s, frm_s, thr_s, ovr_s, txovf_s;
  logic [3:0]        err_id_q;
  logic [CNT_W-1:0]  par_cnt, frm_cnt;

  logic              bad_acc, rd_ok, wr_ok, tx_load, tx_drop, cnt_clr, any_err;
  logic [DATA_W-1:0] status_word, errcnt_word, rd_mux;
  logic [6:0]        irq_src;

  // A rejected access (illegal address/direction or simultaneous strobes) has no side effects.
  assign bad_acc = (w_en && r_en) || (addr >= A_FIRST_UNMAPPED) ||
                   (w_en && addr == A_RX) || (r_en && addr == A_TX);
  assign rd_ok   = r_en && !bad_acc;
  assign wr_ok   = w_en && !bad_acc;
  assign tx_load = wr_ok && addr == A_TX && !tx_valid;
  assign tx_drop = wr_ok && addr == A_TX && tx_valid;
  assign cnt_clr = wr_ok && addr == A_ERRCNT;
  assign any_err = parity_error || frame_error || overrun || threshold;

  // Pop is combinational so the FIFO advances on the same edge that captures its head.
  assign rx_pop  = rd_ok && addr == A_RX && rx_valid && rst;

  assign irq_src = {txovf_s, rx_valid, ~tx_valid, ovr_s, thr_s, frm_s, par_s};
  assign irq     = |(irq_en_q & irq_src);

  always_comb begin
    status_word        = '0;
    status_word[0]     = par_s;
    status_word[1]     = frm_s;
    status_word[2]     = thr_s;
    status_word[3]     = ovr_s;
    status_word[4]     = tx_valid;
    status_word[5]     = rx_valid;
    status_word[6]     = txovf_s;
    status_word[11:8]  = err_id_q;
    errcnt_word        = '0;
    errcnt_word[CNT_W-1:0]       = par_cnt;
    errcnt_word[2*CNT_W-1:CNT_W] = frm_cnt;
    rd_mux = '0;
    if (rd_ok) begin
      case (addr)
        A_CTRL:   rd_mux = config_reg;
        A_STATUS: rd_mux = status_word;
        A_RX:     rd_mux = rx_valid ? rx_data : '0;
        A_IRQEN:  rd_mux[6:0] = irq_en_q;
        A_ERRCNT: rd_mux = errcnt_word;
        A_BAUD:   rd_mux = baud_div;
        default:  rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      config_reg <= '0;
      baud_div   <= DATA_W'(BAUD_RST);
      irq_en_q   <= '0;
    end else if (wr_ok) begin
      if (addr == A_CTRL)  config_reg <= w_data;
      if (addr == A_BAUD)  baud_div   <= w_data;
      if (addr == A_IRQEN) irq_en_q   <= w_data[6:0];
    end
  end

  // Event sets are placed after the W1C clears so a same-cycle event keeps the bit set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_s    <= 1'b0;
      frm_s    <= 1'b0;
      thr_s    <= 1'b0;
      ovr_s    <= 1'b0;
      txovf_s  <= 1'b0;
      err_id_q <= 4'd0;
    end else begin
      if (wr_ok && addr == A_STATUS) begin
        if (w_data[0]) par_s   <= 1'b0;
        if (w_data[1]) frm_s   <= 1'b0;
        if (w_data[2]) thr_s   <= 1'b0;
        if (w_data[3]) ovr_s   <= 1'b0;
        if (w_data[6]) txovf_s <= 1'b0;
      end
      if (parity_error) par_s   <= 1'b1;
      if (frame_error)  frm_s   <= 1'b1;
      if (threshold)    thr_s   <= 1'b1;
      if (overrun)      ovr_s   <= 1'b1;
      if (tx_drop)      txovf_s <= 1'b1;
      if (any_err)      err_id_q <= err_id;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_cnt <= '0;
      frm_cnt <= '0;
    end else begin
      if (cnt_clr)                                 par_cnt <= CNT_W'(parity_error);
      else if (parity_error && par_cnt != CNT_MAX) par_cnt <= par_cnt + CNT_W'(1);
      if (cnt_clr)                                 frm_cnt <= CNT_W'(frame_error);
      else if (frame_error && frm_cnt != CNT_MAX)  frm_cnt <= frm_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (tx_load) begin
      tx_data  <= w_data;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

  // Simultaneous strobes are answered as a rejected write: slverr without read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      slverr  <= 1'b0;
    end else begin
      r_valid <= r_en && !w_en;
      slverr  <= (w_en || r_en) && (bad_acc || tx_drop);
      if (r_en) r_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_uart_csr_bank.sv
// Bench for uart_csr_bank: directed scenarios followed by random traffic, all
// compared each cycle against a register-level reference model.
module tb_uart_csr_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        w_en, r_en;
  logic [3:0]  addr;
  logic [31:0] w_data, r_data, config_reg, baud_div, tx_data, rx_data;
  logic        r_valid, slverr, irq, tx_valid, tx_ready, rx_valid, rx_pop;
  logic        parity_error, frame_error, overrun, threshold;
  logic [3:0]  err_id;

  int tests_run, tests_failed;

  logic [31:0] m_ctrl, m_baud, m_tx_word, m_rdata;
  logic [6:0]  m_irq_en;
  logic        m_par, m_frm, m_thr, m_ovr, m_txovf, m_pend, m_rvalid, m_slverr;
  logic [3:0]  m_id;
  int          m_par_cnt, m_frm_cnt;

  uart_csr_bank dut (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .addr(addr), .w_data(w_data),
    .r_data(r_data), .r_valid(r_valid), .slverr(slverr), .config_reg(config_reg),
    .baud_div(baud_div), .irq(irq), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .parity_error(parity_error), .frame_error(frame_error), .overrun(overrun),
    .threshold(threshold), .err_id(err_id)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_baud = 868; m_tx_word = 0; m_irq_en = 0;
    m_par = 0; m_frm = 0; m_thr = 0; m_ovr = 0; m_txovf = 0; m_pend = 0;
    m_id = 0; m_par_cnt = 0; m_frm_cnt = 0;
    m_rdata = 0; m_rvalid = 0; m_slverr = 0;
  endtask

  function automatic logic [31:0] status_value();
    return (32'(m_id) << 8) | (32'(m_txovf) << 6) | (32'(rx_valid) << 5) |
           (32'(m_pend) << 4) | (32'(m_ovr) << 3) | (32'(m_thr) << 2) |
           (32'(m_frm) << 1) | 32'(m_par);
  endfunction

  // One bus cycle: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    logic        bad, rd_ok, wr_ok, tx_drop, exp_pop, exp_irq;
    logic [31:0] rd;
    logic [6:0]  src;
    #1;
    bad   = (w_en && r_en) || (addr >= 7) || (w_en && addr == 3) || (r_en && addr == 2);
    rd_ok = r_en && !bad;
    wr_ok = w_en && !bad;
    tx_drop = wr_ok && addr == 2 && m_pend;
    rd = 0;
    if (rd_ok) begin
      case (addr)
        4'd0: rd = m_ctrl;
        4'd1: rd = status_value();
        4'd3: rd = rx_valid ? rx_data : 32'd0;
        4'd4: rd = 32'(m_irq_en);
        4'd5: rd = 32'(m_frm_cnt * 256 + m_par_cnt);
        4'd6: rd = m_baud;
        default: rd = 0;
      endcase
    end
    exp_pop = rd_ok && addr == 3 && rx_valid;
    src = {m_txovf, rx_valid, !m_pend, m_ovr, m_thr, m_frm, m_par};
    exp_irq = |(m_irq_en & src);
    check_output("irq", 32'(irq), 32'(exp_irq));
    check_output("rx_pop", 32'(rx_pop), 32'(exp_pop));

    if (wr_ok && addr == 0) m_ctrl = w_data;
    if (wr_ok && addr == 4) m_irq_en = w_data[6:0];
    if (wr_ok && addr == 6) m_baud = w_data;
    if (wr_ok && addr == 1) begin
      if (w_data[0]) m_par = 0;
      if (w_data[1]) m_frm = 0;
      if (w_data[2]) m_thr = 0;
      if (w_data[3]) m_ovr = 0;
      if (w_data[6]) m_txovf = 0;
    end
    if (tx_drop) m_txovf = 1;
    if (parity_error) m_par = 1;
    if (frame_error) m_frm = 1;
    if (threshold) m_thr = 1;
    if (overrun) m_ovr = 1;
    if (parity_error || frame_error || threshold || overrun) m_id = err_id;
    if (wr_ok && addr == 5) begin
      m_par_cnt = parity_error ? 1 : 0;
      m_frm_cnt = frame_error ? 1 : 0;
    end else begin
      if (parity_error && m_par_cnt < 255) m_par_cnt++;
      if (frame_error && m_frm_cnt < 255) m_frm_cnt++;
    end
    if (m_pend) begin
      if (tx_ready) m_pend = 0;
    end else if (wr_ok && addr == 2) begin
      m_pend = 1;
      m_tx_word = w_data;
    end
    m_rvalid = r_en && !w_en;
    m_slverr = (w_en || r_en) && (bad || tx_drop);
    m_rdata  = rd;

    @(posedge clk);
    #1;
    check_output("r_valid", 32'(r_valid), 32'(m_rvalid));
    check_output("slverr", 32'(slverr), 32'(m_slverr));
    if (m_rvalid) check_output("r_data", r_data, m_rdata);
    check_output("tx_valid", 32'(tx_valid), 32'(m_pend));
    if (m_pend) check_output("tx_data", tx_data, m_tx_word);
    check_output("config_reg", config_reg, m_ctrl);
    check_output("baud_div", baud_div, m_baud);
  endtask

  task automatic apply_stimulus(input logic we, input logic re, input logic [3:0] a,
                                input logic [31:0] wd);
    w_en = we; r_en = re; addr = a; w_data = wd;
    step();
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    w_en = 0; r_en = 0; addr = 0; w_data = 0; tx_ready = 0; rx_valid = 0; rx_data = 0;
    parity_error = 0; frame_error = 0; overrun = 0; threshold = 0; err_id = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_r_valid", 32'(r_valid), 32'd0);
    check_output("rst_slverr", 32'(slverr), 32'd0);
    check_output("rst_r_data", r_data, 32'd0);
    check_output("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_output("rst_baud", baud_div, 32'd868);
    check_output("rst_config", config_reg, 32'd0);
    check_output("rst_rx_pop", 32'(rx_pop), 32'd0);
    #3 rst = 1;

    apply_stimulus(0, 1, 6, 0);
    check_output("baud_read", r_data, 32'd868);
    apply_stimulus(0, 1, 0, 0);
    check_output("ctrl_read", r_data, 32'd0);

    tx_ready = 0;
    apply_stimulus(1, 0, 2, 32'hA5);
    repeat (3) apply_stimulus(0, 0, 0, 0);
    apply_stimulus(1, 0, 2, 32'h5A);
    check_output("tx_ovf_slverr", 32'(slverr), 32'd1);
    check_output("tx_data_kept", tx_data, 32'hA5);
    apply_stimulus(0, 1, 1, 0);
    check_output("status_tx_ovf", (r_data >> 6) & 32'h1, 32'h1);
    tx_ready = 1;
    apply_stimulus(0, 0, 0, 0);
    check_output("tx_valid_drop", 32'(tx_valid), 32'd0);
    tx_ready = 0;
    apply_stimulus(1, 0, 1, 32'h40);

    apply_stimulus(1, 0, 5, 0);
    err_id = 3; frame_error = 1;
    repeat (300) apply_stimulus(0, 0, 0, 0);
    frame_error = 0;
    apply_stimulus(0, 1, 5, 0);
    check_output("errcnt_frame_sat", r_data, 32'h0000FF00);
    apply_stimulus(0, 1, 1, 0);
    check_output("status_frame", (r_data >> 1) & 32'h1, 32'h1);
    check_output("status_err_id", (r_data >> 8) & 32'hF, 32'h3);
    apply_stimulus(1, 0, 1, 32'h2);
    apply_stimulus(0, 1, 1, 0);
    check_output("status_frame_clr", (r_data >> 1) & 32'h1, 32'h0);

    parity_error = 1; err_id = 9;
    apply_stimulus(1, 0, 1, 32'h1);
    parity_error = 0;
    apply_stimulus(0, 1, 1, 0);
    check_output("w1c_event_wins", r_data & 32'h1, 32'h1);
    parity_error = 1;
    apply_stimulus(1, 0, 5, 0);
    parity_error = 0;
    apply_stimulus(0, 1, 5, 0);
    check_output("errcnt_clr_event", r_data, 32'h1);

    rx_valid = 1; rx_data = 32'h1234;
    apply_stimulus(0, 1, 3, 0);
    check_output("rx_read", r_data, 32'h1234);
    apply_stimulus(0, 0, 0, 0);
    rx_valid = 0;
    apply_stimulus(0, 1, 3, 0);
    check_output("rx_empty_read", r_data, 32'h0);
    check_output("rx_empty_slverr", 32'(slverr), 32'd0);

    apply_stimulus(1, 0, 1, 32'h4F);
    apply_stimulus(1, 0, 4, 32'h10);
    apply_stimulus(0, 0, 0, 0);
    check_output("irq_tx_idle", 32'(irq), 32'd1);
    apply_stimulus(1, 0, 2, 32'h77);
    #1 check_output("irq_tx_pending", 32'(irq), 32'd0);
    apply_stimulus(1, 0, 0, 32'h55);
    apply_stimulus(1, 1, 0, 32'hDEAD);
    check_output("both_slverr", 32'(slverr), 32'd1);
    check_output("both_ctrl", config_reg, 32'h55);

    parity_error = 1;
    apply_stimulus(0, 0, 0, 0);
    parity_error = 0;
    #3 rst = 0;
    #1;
    check_output("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check_output("midrst_baud", baud_div, 32'd868);
    check_output("midrst_config", config_reg, 32'd0);
    model_reset();
    #2 rst = 1;
    apply_stimulus(0, 1, 5, 0);
    check_output("midrst_errcnt", r_data, 32'd0);
    apply_stimulus(0, 0, 0, 0);
    check_output("midrst_tx_stays_low", 32'(tx_valid), 32'd0);

    for (int i = 0; i < 600; i++) begin
      int op;
      logic [3:0] a_r;
      op  = $urandom_range(0, 9);
      a_r = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      tx_ready     = ($urandom_range(0, 3) == 0);
      rx_valid     = ($urandom_range(0, 1) == 1);
      rx_data      = $urandom;
      parity_error = ($urandom_range(0, 7) == 0);
      frame_error  = ($urandom_range(0, 7) == 0);
      overrun      = ($urandom_range(0, 9) == 0);
      threshold    = ($urandom_range(0, 9) == 0);
      err_id       = 4'($urandom_range(0, 15));
      if (op < 4)       apply_stimulus(0, 1, a_r, 0);
      else if (op < 8)  apply_stimulus(1, 0, a_r, $urandom);
      else if (op == 8) apply_stimulus(1, 1, a_r, $urandom);
      else              apply_stimulus(0, 0, a_r, 0);
    end

    w_en = 0; r_en = 0; parity_error = 0; frame_error = 0; overrun = 0; threshold = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
